crc32_engine: RTL and testbench

//  Iterative CRC-32 engine downstream of control_register. Consumes the

---
 rtl/crc32_engine.sv | 94 +++++++++
 tb/tb_crc32_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/crc32_engine.sv
// Iterative CRC-32 engine: folds BITS_PER_CYCLE bits of a latched word per clock,
// accumulating across words until crc_reset. Reflected or normal bit order per word.
module crc32_engine #(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter logic [31:0] INIT_VALUE     = 32'hFFFFFFFF
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [WORD_SIZE-1:0] crc_data_in,
  input  logic                 crc_reset,
  input  logic                 crc_start,
  input  logic [WORD_SIZE-1:0] crc_orient,
  output logic [WORD_SIZE-1:0] crc_out,
  output logic                 crc_ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int unsigned CW = $clog2(WORD_SIZE) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WORD_SIZE / BITS_PER_CYCLE);

  localparam logic [WORD_SIZE-1:0] POLY_REFL = 32'hEDB88320;
  localparam logic [WORD_SIZE-1:0] POLY_NORM = 32'h04C11DB7;

  logic [0:0]           state;
  logic [WORD_SIZE-1:0] crc_reg;
  logic [WORD_SIZE-1:0] data_q;
  logic [1:0]           orient_q;
  logic [CW-1:0]        cnt;

  logic [WORD_SIZE-1:0] crc_nxt;
  logic [WORD_SIZE-1:0] data_nxt;
  logic                 fb;
  logic                 unused_orient;

  assign unused_orient = ^crc_orient[WORD_SIZE-1:2];

  // The data word is shifted alongside the CRC so the next bit to fold is
  // always at a fixed position (bit 0 when reflected, MSB otherwise).
  always_comb begin
    crc_nxt  = crc_reg;
    data_nxt = data_q;
    fb       = 1'b0;
    for (int unsigned b = 0; b < BITS_PER_CYCLE; b++) begin
      if (orient_q[0]) begin
        fb       = crc_nxt[0] ^ data_nxt[0];
        crc_nxt  = (crc_nxt >> 1) ^ (fb ? POLY_REFL : '0);
        data_nxt = data_nxt >> 1;
      end else begin
        fb       = crc_nxt[WORD_SIZE-1] ^ data_nxt[WORD_SIZE-1];
        crc_nxt  = (crc_nxt << 1) ^ (fb ? POLY_NORM : '0);
        data_nxt = data_nxt << 1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      crc_reg  <= INIT_VALUE;
      data_q   <= '0;
      orient_q <= '0;
      cnt      <= '0;
    end else if (crc_reset) begin
      state   <= IDLE;
      crc_reg <= INIT_VALUE;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (crc_start) begin
            data_q   <= crc_data_in;
            orient_q <= crc_orient[1:0];
            cnt      <= CNT_LOAD;
            state    <= BUSY;
          end
        end
        BUSY: begin
          crc_reg <= crc_nxt;
          data_q  <= data_nxt;
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign crc_ready = (state == IDLE);
  assign crc_out   = crc_reg ^ (orient_q[1] ? '1 : '0);

endmodule

// File: tb/tb_crc32_engine.sv
// Directed bench for crc32_engine: three instances (1, 8, 32 bits per cycle)
// share stimulus and are checked against a bitwise CRC-32 model.
module tb_crc32_engine;

  logic        CLK;
  logic        nRST;
  logic [31:0] crc_data_in;
  logic        crc_reset;
  logic        crc_start;
  logic [31:0] crc_orient;
  logic [31:0] out1, out8, out32;
  logic        rdy1, rdy8, rdy32;

  int total = 0;
  int bad   = 0;
  int lat1, lat8, lat32;
  logic [31:0] model_crc;
  logic [31:0] exp_v;
  logic [31:0] d;
  logic [1:0]  o;

  crc32_engine #(.BITS_PER_CYCLE(1)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .crc_data_in(crc_data_in), .crc_reset(crc_reset),
    .crc_start(crc_start), .crc_orient(crc_orient), .crc_out(out1), .crc_ready(rdy1));
  crc32_engine #(.BITS_PER_CYCLE(8)) u_dut8 (
    .CLK(CLK), .nRST(nRST), .crc_data_in(crc_data_in), .crc_reset(crc_reset),
    .crc_start(crc_start), .crc_orient(crc_orient), .crc_out(out8), .crc_ready(rdy8));
  crc32_engine #(.BITS_PER_CYCLE(32)) u_dut32 (
    .CLK(CLK), .nRST(nRST), .crc_data_in(crc_data_in), .crc_reset(crc_reset),
    .crc_start(crc_start), .crc_orient(crc_orient), .crc_out(out32), .crc_ready(rdy32));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fold32(input logic [31:0] c, input logic [31:0] dw,
                                         input logic refl);
    logic f;
    for (int i = 0; i < 32; i++) begin
      if (refl) begin
        f = c[0] ^ dw[i];
        c = (c >> 1) ^ (f ? 32'hEDB88320 : 32'h0);
      end else begin
        f = c[31] ^ dw[31-i];
        c = (c << 1) ^ (f ? 32'h04C11DB7 : 32'h0);
      end
    end
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    crc_reset = 1'b1;
    tick(1);
    crc_reset = 1'b0;
  endtask

  // Scrambles inputs after the accept edge so in-flight words must use latched copies.
  task automatic start_word(input logic [31:0] dw, input logic [1:0] ow);
    crc_data_in = dw;
    crc_orient  = {30'h0, ow};
    crc_start   = 1'b1;
    tick(1);
    crc_start   = 1'b0;
    crc_data_in = ~dw;
    crc_orient  = ~{30'h0, ow};
  endtask

  task automatic run_word(input logic [31:0] dw, input logic [1:0] ow);
    start_word(dw, ow);
    lat1 = 0; lat8 = 0; lat32 = 0;
    for (int t = 1; t <= 40; t++) begin
      tick(1);
      if (rdy1  && lat1  == 0) lat1  = t;
      if (rdy8  && lat8  == 0) lat8  = t;
      if (rdy32 && lat32 == 0) lat32 = t;
    end
  endtask

  initial begin
    nRST = 1'b0; crc_reset = 1'b0; crc_start = 1'b0;
    crc_data_in = '0; crc_orient = '0;
    tick(2);
    chk("rst_out", out1, 32'hFFFFFFFF);
    chk("rst_rdy", {31'h0, rdy1}, 32'h1);
    nRST = 1'b1;

    // reset alone leaves latched orient at 0, so raw INIT is visible
    crc_orient = 32'h3;
    do_reset();
    chk("crst_out", out1, 32'hFFFFFFFF);
    chk("crst_rdy", {31'h0, rdy1}, 32'h1);

    do_reset();
    run_word(32'h0, 2'b11);
    chk("lat_bpc1",  lat1,  32);
    chk("lat_bpc8",  lat8,  4);
    chk("lat_bpc32", lat32, 1);
    chk("zero4_b1",  out1,  32'h2144DF1C);
    chk("zero4_b8",  out8,  32'h2144DF1C);
    chk("zero4_b32", out32, 32'h2144DF1C);

    do_reset();
    run_word(32'hFFFFFFFF, 2'b00);
    chk("ones_raw_b1",  out1,  32'h00000000);
    chk("ones_raw_b8",  out8,  32'h00000000);
    chk("ones_raw_b32", out32, 32'h00000000);
    do_reset();
    run_word(32'hFFFFFFFF, 2'b11);
    chk("ones_refl_b1",  out1,  32'hFFFFFFFF);
    chk("ones_refl_b32", out32, 32'hFFFFFFFF);

    // start while busy is ignored
    do_reset();
    start_word(32'h0, 2'b11);
    tick(4);
    crc_data_in = 32'hFFFFFFFF;
    crc_start   = 1'b1;
    tick(1);
    crc_start   = 1'b0;
    chk("busy_rdy", {31'h0, rdy1}, 32'h0);
    lat1 = 0;
    for (int t = 0; t < 40 && !rdy1; t++) tick(1);
    chk("busy_ready_seen", {31'h0, rdy1}, 32'h1);
    chk("busy_ignored", out1, 32'h2144DF1C);
    run_word(32'h0, 2'b11);
    exp_v = fold32(fold32(32'hFFFFFFFF, 32'h0, 1'b1), 32'h0, 1'b1) ^ 32'hFFFFFFFF;
    chk("zero8", out1, exp_v);
    chk("zero8_lat", lat1, 32);

    // crc_reset aborts a word in flight
    do_reset();
    start_word(32'h12345678, 2'b11);
    tick(9);
    chk("abort_busy", {31'h0, rdy1}, 32'h0);
    crc_reset = 1'b1;
    tick(1);
    crc_reset = 1'b0;
    chk("abort_rdy", {31'h0, rdy1}, 32'h1);
    chk("abort_out", out1, 32'h00000000);
    crc_reset = 1'b1; crc_start = 1'b1; crc_data_in = 32'hA5A5A5A5;
    tick(1);
    crc_reset = 1'b0; crc_start = 1'b0;
    chk("rst_start_rdy", {31'h0, rdy1}, 32'h1);
    tick(1);
    chk("rst_start_rdy2", {31'h0, rdy1}, 32'h1);
    chk("rst_start_out", out1, 32'h00000000);

    // start held high: one accept per idle visit
    crc_data_in = 32'h0; crc_orient = 32'h3; crc_start = 1'b1;
    tick(1);
    chk("hold_busy", {31'h0, rdy1}, 32'h0);
    tick(31);
    chk("hold_busy31", {31'h0, rdy1}, 32'h0);
    tick(1);
    chk("hold_idle", {31'h0, rdy1}, 32'h1);
    chk("hold_out", out1, 32'h2144DF1C);
    tick(1);
    chk("hold_reaccept", {31'h0, rdy1}, 32'h0);
    crc_start = 1'b0;
    do_reset();

    // random words, accumulating across words between resets
    model_crc = 32'hFFFFFFFF;
    for (int k = 0; k < 8; k++) begin
      if (k % 3 == 0) begin
        do_reset();
        model_crc = 32'hFFFFFFFF;
      end
      d = $urandom;
      o = 2'($urandom_range(0, 3));
      run_word(d, o);
      model_crc = fold32(model_crc, d, o[0]);
      exp_v = model_crc ^ (o[1] ? 32'hFFFFFFFF : 32'h0);
      chk("rand_b1",  out1,  exp_v);
      chk("rand_b8",  out8,  exp_v);
      chk("rand_b32", out32, exp_v);
    end

    // async nRST mid-word
    start_word($urandom, 2'b11);
    tick(3);
    #2 nRST = 1'b0;
    #1;
    chk("arst_rdy", {29'h0, rdy32, rdy8, rdy1}, 32'h7);
    chk("arst_out", out1, 32'hFFFFFFFF);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    d = $urandom;
    run_word(d, 2'b01);
    exp_v = fold32(32'hFFFFFFFF, d, 1'b1);
    chk("post_arst_b1", out1, exp_v);
    chk("post_arst_b8", out8, exp_v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
